pipe_skid_reg: RTL and testbench
================================

Name: pipe_skid_reg

Overview:
- Registered pipeline stage directly downstream of the 2:1 datapath mux; captures the selected operand and presents it to the next datapath unit.
- Uses a valid/ready handshake with a two-entry skid buffer.
- Sustains one transfer per cycle with a fully registered input-side ready, which breaks the mux-to-consumer critical path.

Parameters:
- DATAWIDTH, 2, width of the data word (matches upstream mux width).
- STALLCNTW, 16, width of the stall counter (used only with the optional feature).

Ports:
- Clk  input  1  rising-edge clock, single clock domain.
- Rst  input  1  asynchronous, active-low reset (block in reset while Rst=0).
- in_data  input  DATAWIDTH  word from upstream mux output d.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  stage can accept a word this cycle.
- out_data  output  DATAWIDTH  registered word to downstream unit.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data this cycle.
- occupancy  output  2  number of held words (0, 1 or 2).
- stall_cnt  output  STALLCNTW  present only with PIPE_SKID_REG_STALL_CNT_EN.

Behaviour:
- Handshake and latency:
  - Input transfer occurs when in_valid & in_ready at a rising edge; output transfer occurs when out_valid & out_ready at a rising edge.
  - Latency is 1 cycle: a word accepted at edge N is on out_data/out_valid after edge N.
- Storage: main register (drives out_data) and skid register.
- State machine, held in one state register:
  - EMPTY (occupancy 0).
  - ONE (occupancy 1).
  - FULL (occupancy 2).
- Output decode, all decoded from registers only:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL).
  - No combinational path from out_ready or in_valid to in_ready.
- Transitions:
  - EMPTY: in_valid -> main<=in_data, go to ONE; otherwise stay.
  - ONE, in_valid & out_ready -> main<=in_data, stay ONE (simultaneous in/out, full throughput).
  - ONE, in_valid & !out_ready -> skid<=in_data, go to FULL; main holds.
  - ONE, !in_valid & out_ready -> go to EMPTY.
  - ONE, neither -> hold.
  - FULL: in_ready=0, so in_valid is ignored. On out_ready -> main<=skid, go to ONE; otherwise hold.
- Data stability: while out_valid & !out_ready, out_data must not change; verified by assertion.
- Ordering: words leave strictly in acceptance order; no drop, no duplication.
- Reset (Rst=0, async assert, deasserts synchronously to Clk):
  - state=EMPTY, main=0, skid=0.
  - Outputs: out_valid=0, out_data=0, in_ready=1, occupancy=0, stall_cnt=0.
  - Reset mid-operation discards all held words immediately, with no output transfer.
- in_data is sampled only when accepted; X on in_data while in_valid=0 must not propagate.

Optional Feature:
- Macro: PIPE_SKID_REG_STALL_CNT_EN.
- Defined:
  - stall_cnt increments by 1 each cycle with out_valid=1 & out_ready=0.
  - Saturates at all-ones; never wraps.
  - Cleared only by reset.
- Undefined: stall_cnt port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Package pipe_skid_pkg:
  - state enum (EMPTY=2'd0, ONE=2'd1, FULL=2'd2).
  - Constant OCC_W=2.
- One sub-module, pipe_data_reg: DATAWIDTH-wide enabled register with async active-low clear. Instantiated twice (main, skid).

Test Plan:
- Reset then idle, DATAWIDTH=2:
  - Assert Rst=0 for 3 cycles -> out_valid=0, out_data=2'b00, in_ready=1, occupancy=0.
- Streaming:
  - Drive 2'b01,2'b10,2'b11 on consecutive cycles with out_ready=1 -> same sequence on out_data one cycle later, out_valid=1 for 3 cycles, occupancy never exceeds 1.
- Backpressure fill:
  - With out_ready=0, send 2'b01 then 2'b10 -> occupancy=2, in_ready=0.
  - A third word 2'b11 is held off.
  - Raise out_ready -> outputs 01, 10, 11 in order.
- Simultaneous in/out in ONE:
  - Held word 2'b01, in_valid with 2'b10 and out_ready=1 on same edge -> out_data=2'b10 next cycle, occupancy stays 1.
- Reset mid-FULL:
  - With occupancy=2, pulse Rst=0 asynchronously between edges -> out_valid drops immediately, in_ready=1.
  - Neither held word appears after release.
- Stall counter (macro defined, STALLCNTW=4):
  - Hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=4'hF, saturated.
  - Reset -> 0.

Source files
------------

// File: rtl/pipe_skid_pkg.sv
// Shared types and constants for the pipe_skid_reg stage.
package pipe_skid_pkg;

  localparam int unsigned OCC_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_data_reg.sv
// DATAWIDTH-wide load-enabled register with asynchronous active-low clear.
module pipe_data_reg #(
  parameter int unsigned DATAWIDTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [DATAWIDTH-1:0] d_i,
  output logic [DATAWIDTH-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Registered valid/ready pipeline stage with a two-entry skid buffer.
// Optional stall counter enabled by defining PIPE_SKID_REG_STALL_CNT_EN.
module pipe_skid_reg
  import pipe_skid_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 2,
  parameter int unsigned STALLCNTW = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OCC_W-1:0]     occupancy
`ifdef PIPE_SKID_REG_STALL_CNT_EN
  ,
  output logic [STALLCNTW-1:0] stall_cnt
`endif
);

  if (DATAWIDTH == 0 || STALLCNTW == 0) begin : g_cfg_err
    $error("pipe_skid_reg: DATAWIDTH and STALLCNTW must be nonzero");
  end

  state_e               state_q, state_d;
  logic                 main_en, skid_en, main_from_skid;
  logic [DATAWIDTH-1:0] main_d, main_q, skid_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (in_valid) state_d = ONE;
      ONE: begin
        if (in_valid && !out_ready) begin
          state_d = FULL;
        end else if (!in_valid && out_ready) begin
          state_d = EMPTY;
        end
      end
      FULL:    if (out_ready) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // in_ready/out_valid/occupancy depend on state_q alone; only the data
  // enables look at the handshake inputs.
  always_comb begin
    out_valid      = 1'b0;
    in_ready       = 1'b1;
    occupancy      = '0;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        main_en = in_valid;
      end
      ONE: begin
        out_valid = 1'b1;
        occupancy = OCC_W'(1);
        main_en   = in_valid && out_ready;
        skid_en   = in_valid && !out_ready;
      end
      FULL: begin
        out_valid      = 1'b1;
        in_ready       = 1'b0;
        occupancy      = OCC_W'(2);
        main_en        = out_ready;
        main_from_skid = 1'b1;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  pipe_data_reg #(.DATAWIDTH(DATAWIDTH)) u_main (
    .clk_i  (Clk),
    .rst_ni (Rst),
    .en_i   (main_en),
    .d_i    (main_d),
    .q_o    (main_q)
  );

  pipe_data_reg #(.DATAWIDTH(DATAWIDTH)) u_skid (
    .clk_i  (Clk),
    .rst_ni (Rst),
    .en_i   (skid_en),
    .d_i    (in_data),
    .q_o    (skid_q)
  );

  assign out_data = main_q;

`ifdef PIPE_SKID_REG_STALL_CNT_EN
  logic [STALLCNTW-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_d = stall_q + STALLCNTW'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

  a_out_stable : assert property (@(posedge Clk) disable iff (!Rst)
    (out_valid && !out_ready) |=> $stable(out_data));

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg; the stall-counter scenario runs
// only when PIPE_SKID_REG_STALL_CNT_EN is defined.
module tb_pipe_skid_reg;

  localparam int unsigned DW = 2;
  localparam int unsigned SW = 4;

  logic          Clk;
  logic          Rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [1:0]    occupancy;
`ifdef PIPE_SKID_REG_STALL_CNT_EN
  logic [SW-1:0] stall_cnt;
`endif

  int unsigned   n_checks;
  int unsigned   n_fails;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] obs_q[$];
  logic [DW-1:0] e, o;

  pipe_skid_reg #(
    .DATAWIDTH (DW),
    .STALLCNTW (SW)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
`ifdef PIPE_SKID_REG_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Record transfers just before the edge that performs them, then step to #1 after it.
  task automatic tick();
    @(negedge Clk);
    if (Rst) begin
      if (out_valid && out_ready) obs_q.push_back(out_data);
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_data !== 2'b00) begin n_fails++; $display("FAIL reset_out_data: got %b expected 00", out_data); end
    n_checks++; if (in_ready !== 1'b1) begin n_fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (occupancy !== 2'd0) begin n_fails++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
    Rst = 1'b1;
    tick();
  endtask

  task automatic test_streaming();
    logic [DW-1:0] words [3];
    words[0] = 2'b01; words[1] = 2'b10; words[2] = 2'b11;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = words[i];
      tick();
      n_checks++; if (out_valid !== 1'b1 || out_data !== words[i]) begin
        n_fails++; $display("FAIL stream_word%0d: got v=%b d=%b expected v=1 d=%b", i, out_valid, out_data, words[i]);
      end
      n_checks++; if (occupancy !== 2'd1) begin n_fails++; $display("FAIL stream_occ%0d: got %0d expected 1", i, occupancy); end
    end
    in_valid = 1'b0; in_data = 'x;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL stream_drain: got %b expected 0", out_valid); end
    n_checks++; if (out_data !== 2'b11) begin n_fails++; $display("FAIL stream_x_hold: got %b expected 11", out_data); end
    n_checks++; if (obs_q.size() != 3) begin n_fails++; $display("FAIL stream_count: got %0d expected 3", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fails++; $display("FAIL stream_order: got %b expected %b", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    in_data = '0;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 2'b01; tick();
    in_data = 2'b10; tick();
    n_checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
      n_fails++; $display("FAIL bp_full: got occ=%0d rdy=%b expected occ=2 rdy=0", occupancy, in_ready);
    end
    in_data = 2'b11; tick();
    n_checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 2'b01) begin
      n_fails++; $display("FAIL bp_hold: got occ=%0d rdy=%b d=%b expected occ=2 rdy=0 d=01", occupancy, in_ready, out_data);
    end
    out_ready = 1'b1; tick();
    n_checks++; if (out_data !== 2'b10 || in_ready !== 1'b1 || occupancy !== 2'd1) begin
      n_fails++; $display("FAIL bp_unskid: got d=%b rdy=%b occ=%0d expected d=10 rdy=1 occ=1", out_data, in_ready, occupancy);
    end
    tick();
    n_checks++; if (out_data !== 2'b11) begin n_fails++; $display("FAIL bp_third: got %b expected 11", out_data); end
    in_valid = 1'b0; tick();
    n_checks++; if (exp_q.size() != 3 || obs_q.size() != 3) begin
      n_fails++; $display("FAIL bp_count: got acc=%0d out=%0d expected 3/3", exp_q.size(), obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fails++; $display("FAIL bp_order: got %b expected %b", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 2'b01; tick();
    in_data = 2'b10; out_ready = 1'b1; tick();
    n_checks++; if (out_data !== 2'b10 || occupancy !== 2'd1) begin
      n_fails++; $display("FAIL simul: got d=%b occ=%0d expected d=10 occ=1", out_data, occupancy);
    end
    in_valid = 1'b0; tick();
    n_checks++; if (obs_q.size() != 2 || out_valid !== 1'b0) begin
      n_fails++; $display("FAIL simul_count: got out=%0d v=%b expected 2 v=0", obs_q.size(), out_valid);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fails++; $display("FAIL simul_order: got %b expected %b", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_full();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 2'b01; tick();
    in_data = 2'b10; tick();
    in_valid = 1'b0;
    n_checks++; if (occupancy !== 2'd2) begin n_fails++; $display("FAIL rmf_pre: got %0d expected 2", occupancy); end
    #2 Rst = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_data !== 2'b00) begin
      n_fails++; $display("FAIL rmf_async: got v=%b rdy=%b occ=%0d d=%b expected v=0 rdy=1 occ=0 d=00",
                          out_valid, in_ready, occupancy, out_data);
    end
    exp_q.delete(); obs_q.delete();
    tick();
    Rst = 1'b1; out_ready = 1'b1;
    repeat (3) tick();
    n_checks++; if (obs_q.size() != 0 || out_valid !== 1'b0) begin
      n_fails++; $display("FAIL rmf_ghost: got out=%0d v=%b expected 0 v=0", obs_q.size(), out_valid);
    end
    exp_q.delete(); obs_q.delete();
  endtask

`ifdef PIPE_SKID_REG_STALL_CNT_EN
  task automatic test_stall_cnt();
    Rst = 1'b0; tick(); Rst = 1'b1;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 2'b01; tick();
    in_valid = 1'b0;
    repeat (5) tick();
    n_checks++; if (stall_cnt !== 4'd5) begin n_fails++; $display("FAIL stall_partial: got %0d expected 5", stall_cnt); end
    repeat (15) tick();
    n_checks++; if (stall_cnt !== 4'hF) begin n_fails++; $display("FAIL stall_sat: got %0h expected f", stall_cnt); end
    #2 Rst = 1'b0;
    #1;
    n_checks++; if (stall_cnt !== 4'd0) begin n_fails++; $display("FAIL stall_reset: got %0h expected 0", stall_cnt); end
    tick();
    Rst = 1'b1;
    exp_q.delete(); obs_q.delete();
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fails  = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_simultaneous();
    test_reset_mid_full();
`ifdef PIPE_SKID_REG_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
